sbus_frame_ctrl: RTL and testbench

Sequences the S-Bus byte receiver into complete 25-byte S-Bus frames: header 0x0F, 22 payload bytes, flags, footer 0x00.
- Unpacks 16 x 11-bit channels and publishes them atomically, together with the flag bits.
- Supervises the byte receiver, which latches in an error state: it pulses the receiver's active-low reset to resynchronise after any byte error, gap timeout or frame error.
- Sits between the byte receiver and the flight-control register bank.

---
 rtl/sbus_pkg.sv | 24 ++
 rtl/sbus_ch_unpack.sv | 52 +++++
 rtl/sbus_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sbus_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbus_pkg.sv
// Shared S-Bus constants, FSM state type and flag bit positions.
package sbus_pkg;

  localparam logic [7:0]  SBUS_HEADER        = 8'h0F;
  localparam logic [7:0]  SBUS_FOOTER        = 8'h00;
  localparam int unsigned SBUS_PAYLOAD_BYTES = 22;
  localparam int unsigned SBUS_NUM_CH        = 16;
  localparam int unsigned SBUS_CH_W          = 11;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_FLAGS,
    ST_FOOTER,
    ST_RECOVER
  } sbus_state_e;

  // Bit positions inside the S-Bus flags byte.
  localparam int unsigned FLAG_CH17       = 0;
  localparam int unsigned FLAG_CH18       = 1;
  localparam int unsigned FLAG_FRAME_LOST = 2;
  localparam int unsigned FLAG_FAILSAFE   = 3;

endpackage

// File: rtl/sbus_ch_unpack.sv
// LSB-first bit accumulator: takes payload bytes, emits one 11-bit
// channel word whenever at least 11 bits are held.
module sbus_ch_unpack
  import sbus_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 byte_vld_i,
  input  logic [7:0]           byte_i,
  output logic                 word_vld_o,
  output logic [SBUS_CH_W-1:0] word_o,
  output logic                 empty_o
);

  // At most 10 bits remain between bytes, so 18 bits cover the worst case.
  logic [17:0] acc_q, acc_d, merged;
  logic [4:0]  cnt_q, cnt_d, total;

  // Merge the incoming byte above the held bits and split off a full word.
  always_comb begin
    merged     = acc_q | (18'(byte_i) << cnt_q);
    total      = cnt_q + 5'd8;
    word_vld_o = byte_vld_i && (total >= 5'd11);
    word_o     = merged[SBUS_CH_W-1:0];
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (byte_vld_i) begin
      if (total >= 5'd11) begin
        acc_d = merged >> 11;
        cnt_d = total - 5'd11;
      end else begin
        acc_d = merged;
        cnt_d = total;
      end
    end
  end

  // Accumulator state; cleared between frames.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign empty_o = (cnt_q == 5'd0);

endmodule

// File: rtl/sbus_frame_ctrl.sv
// S-Bus frame sequencer: frames bytes from the byte receiver, unpacks
// 16 channels, publishes them atomically and resets the receiver after
// any error. Optional link watchdog: define SBUS_LINK_WATCHDOG_EN.
module sbus_frame_ctrl
  import sbus_pkg::*;
#(
  parameter int unsigned GAP_TICKS       = 50000,
  parameter int unsigned UART_RST_CYCLES = 4,
  parameter int unsigned WATCHDOG_TICKS  = 10000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic [7:0]   uart_data_i,
  input  logic         uart_rdy_i,
  input  logic         uart_err_i,
  output logic         uart_rst_no,
  output logic [175:0] channels_o,
  output logic         ch17_o,
  output logic         ch18_o,
  output logic         frame_lost_o,
  output logic         failsafe_o,
  output logic         frame_valid_o,
  output logic         frame_err_o,
  output logic [15:0]  err_cnt_o,
  output logic         link_lost_o
);

  sbus_state_e state_q, state_d;

  logic [4:0]  byte_idx_q;
  logic [3:0]  ch_idx_q;
  logic [SBUS_NUM_CH-1:0][SBUS_CH_W-1:0] shadow_ch_q, channels_q;
  logic [3:0]  shadow_flags_q, flags_q;
  logic [31:0] gap_cnt_q, rec_cnt_q;
  logic [15:0] err_cnt_q;
  logic        valid_q, err_q;

  logic        frame_err, frame_ok, byte_take, flags_take, unpack_clr, gap_to;
  logic        word_vld, unpack_empty;
  logic [SBUS_CH_W-1:0] word;

  sbus_ch_unpack u_unpack (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (unpack_clr),
    .byte_vld_i (byte_take),
    .byte_i     (uart_data_i),
    .word_vld_o (word_vld),
    .word_o     (word),
    .empty_o    (unpack_empty)
  );

  // Next-state and control decode; disable beats receiver error beats gap beats data.
  always_comb begin
    state_d    = state_q;
    frame_err  = 1'b0;
    frame_ok   = 1'b0;
    byte_take  = 1'b0;
    flags_take = 1'b0;
    unpack_clr = 1'b0;
    gap_to     = (gap_cnt_q >= 32'(GAP_TICKS - 1)) && !uart_rdy_i;
    if (state_q == ST_RECOVER) begin
      unpack_clr = 1'b1;
      if (enable_i && (rec_cnt_q >= 32'(UART_RST_CYCLES - 1)))
        state_d = ST_HDR;
    end else if (!enable_i) begin
      state_d = ST_RECOVER;
    end else if (uart_err_i) begin
      state_d   = ST_RECOVER;
      frame_err = (state_q != ST_HDR);
    end else begin
      case (state_q)
        ST_HDR: begin
          unpack_clr = 1'b1;
          if (uart_rdy_i && (uart_data_i == SBUS_HEADER)) state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (gap_to) frame_err = 1'b1;
          else if (uart_rdy_i) begin
            byte_take = 1'b1;
            if (byte_idx_q == 5'(SBUS_PAYLOAD_BYTES - 1)) state_d = ST_FLAGS;
          end
        end
        ST_FLAGS: begin
          if (gap_to || (uart_rdy_i && !unpack_empty)) frame_err = 1'b1;
          else if (uart_rdy_i) begin
            flags_take = 1'b1;
            state_d    = ST_FOOTER;
          end
        end
        ST_FOOTER: begin
          if (gap_to) frame_err = 1'b1;
          else if (uart_rdy_i) begin
            if (uart_data_i == SBUS_FOOTER) begin
              frame_ok = 1'b1;
              state_d  = ST_HDR;
            end else begin
              frame_err = 1'b1;
            end
          end
        end
        default: state_d = ST_RECOVER;
      endcase
      if (frame_err) state_d = ST_RECOVER;
    end
  end

  // State register; reset starts in recovery so the receiver gets a reset pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RECOVER;
    else       state_q <= state_d;
  end

  // Frame datapath: indices, shadow capture, publish, timers and error count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_idx_q     <= '0;
      ch_idx_q       <= '0;
      shadow_ch_q    <= '0;
      shadow_flags_q <= '0;
      channels_q     <= '0;
      flags_q        <= '0;
      gap_cnt_q      <= '0;
      rec_cnt_q      <= '0;
      err_cnt_q      <= '0;
      valid_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      valid_q <= frame_ok;
      err_q   <= frame_err;
      if (frame_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
      if (frame_ok) begin
        channels_q <= shadow_ch_q;
        flags_q    <= shadow_flags_q;
      end
      if (state_q == ST_HDR) begin
        byte_idx_q <= '0;
        ch_idx_q   <= '0;
      end else if (byte_take) begin
        byte_idx_q <= byte_idx_q + 5'd1;
      end
      if (state_q == ST_RECOVER) begin
        shadow_ch_q    <= '0;
        shadow_flags_q <= '0;
      end else begin
        if (word_vld) begin
          shadow_ch_q[ch_idx_q] <= word;
          ch_idx_q              <= ch_idx_q + 4'd1;
        end
        if (flags_take) shadow_flags_q <= uart_data_i[3:0];
      end
      if ((state_q == ST_HDR) || (state_q == ST_RECOVER) || uart_rdy_i) gap_cnt_q <= '0;
      else                                                              gap_cnt_q <= gap_cnt_q + 32'd1;
      if ((state_q != ST_RECOVER) || !enable_i) rec_cnt_q <= '0;
      else                                      rec_cnt_q <= rec_cnt_q + 32'd1;
    end
  end

  assign uart_rst_no   = (state_q != ST_RECOVER);
  assign channels_o    = channels_q;
  assign ch17_o        = flags_q[FLAG_CH17];
  assign ch18_o        = flags_q[FLAG_CH18];
  assign frame_lost_o  = flags_q[FLAG_FRAME_LOST];
  assign frame_valid_o = valid_q;
  assign frame_err_o   = err_q;
  assign err_cnt_o     = err_cnt_q;

`ifdef SBUS_LINK_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        link_lost_q;

  // Watchdog: cleared on each accepted frame, trips after WATCHDOG_TICKS idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i || frame_ok) begin
      wd_cnt_q    <= '0;
      link_lost_q <= 1'b0;
    end else begin
      if (wd_cnt_q != '1) wd_cnt_q <= wd_cnt_q + 32'd1;
      if (wd_cnt_q >= 32'(WATCHDOG_TICKS - 1)) link_lost_q <= 1'b1;
    end
  end

  assign link_lost_o = link_lost_q;
  assign failsafe_o  = flags_q[FLAG_FAILSAFE] | link_lost_q;
`else
  assign link_lost_o = 1'b0;
  assign failsafe_o  = flags_q[FLAG_FAILSAFE];
`endif

endmodule

// File: tb/tb_sbus_frame_ctrl.sv
// Self-checking bench for sbus_frame_ctrl: constant vector table, hand
// corner-case sequences and random frames against a bit-stream model.
module tb_sbus_frame_ctrl;

  localparam int unsigned GAP_TICKS       = 64;
  localparam int unsigned UART_RST_CYCLES = 4;
  localparam int unsigned WATCHDOG_TICKS  = 1000;

  logic         clk = 1'b0;
  logic         rst_i, enable_i, uart_rdy_i, uart_err_i;
  logic [7:0]   uart_data_i;
  logic         uart_rst_no, ch17_o, ch18_o, frame_lost_o, failsafe_o;
  logic         frame_valid_o, frame_err_o, link_lost_o;
  logic [175:0] channels_o;
  logic [15:0]  err_cnt_o;

  sbus_frame_ctrl #(
    .GAP_TICKS       (GAP_TICKS),
    .UART_RST_CYCLES (UART_RST_CYCLES),
    .WATCHDOG_TICKS  (WATCHDOG_TICKS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .uart_data_i   (uart_data_i),
    .uart_rdy_i    (uart_rdy_i),
    .uart_err_i    (uart_err_i),
    .uart_rst_no   (uart_rst_no),
    .channels_o    (channels_o),
    .ch17_o        (ch17_o),
    .ch18_o        (ch18_o),
    .frame_lost_o  (frame_lost_o),
    .failsafe_o    (failsafe_o),
    .frame_valid_o (frame_valid_o),
    .frame_err_o   (frame_err_o),
    .err_cnt_o     (err_cnt_o),
    .link_lost_o   (link_lost_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the published channel field is the payload bit stream itself.
  logic [175:0] m_ch;
  logic [3:0]   m_flags;
  int           m_err;

  typedef struct {
    logic [7:0]  fill, b1, b2, flags, footer;
    logic        exp_ok;
    logic [10:0] e_ch0, e_ch1, e_ch15;
    logic [3:0]  e_flags;
  } vec_t;

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    uart_data_i = b;
    uart_rdy_i  = 1'b1;
    uart_err_i  = err;
    tick();
    uart_rdy_i  = 1'b0;
    uart_err_i  = 1'b0;
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (uart_rst_no == 1'b0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".ch"},    channels_o, m_ch);
    chk({tag, ".flags"}, 176'({failsafe_o, frame_lost_o, ch18_o, ch17_o}), 176'(m_flags));
    chk({tag, ".errcnt"}, 176'(err_cnt_o), 176'(m_err));
    chk({tag, ".link"},  176'(link_lost_o), 176'(0));
  endtask

  // Sends header, payload, flags, footer; err_at injects uart_err with that byte.
  task automatic do_frame(input logic [175:0] pl, input logic [7:0] fl, input logic [7:0] ft,
                          input int err_at, input int gap_at, input int gap_len,
                          input string tag, output logic seen_ok);
    logic [7:0] bytes [25];
    logic       ok;
    int         n;
    bytes[0] = 8'h0F;
    for (int i = 0; i < 22; i++) bytes[i+1] = pl[8*i +: 8];
    bytes[23] = fl;
    bytes[24] = ft;
    for (int i = 0; i < 25; i++) begin
      if (i == err_at) begin
        send_byte(bytes[i], 1'b1);
        break;
      end
      send_byte(bytes[i], 1'b0);
      if (i < 24) begin
        if (i == gap_at) repeat (gap_len) tick();
        else             repeat ($urandom_range(0, 2)) tick();
      end
    end
    ok      = (err_at < 0) && (ft == 8'h00);
    seen_ok = frame_valid_o;
    chk({tag, ".valid"}, 176'(frame_valid_o), 176'(ok));
    chk({tag, ".err"},   176'(frame_err_o),   176'(!ok));
    if (ok) begin
      m_ch    = pl;
      m_flags = fl[3:0];
    end else if (m_err < 16'hFFFF) begin
      m_err++;
    end
    chk_state(tag);
    if (!ok) begin
      count_low(n);
      chk({tag, ".rstlow"}, 176'(n), 176'(UART_RST_CYCLES));
    end else begin
      tick();
    end
    chk({tag, ".pulse"}, 176'({frame_valid_o, frame_err_o}), 176'(0));
  endtask

  vec_t         tbl [6];
  logic [175:0] pl;
  logic         seen;
  int           n;

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 11'h7FF, 11'h7FF, 11'h7FF, 4'h0};
    tbl[1] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 11'h001, 11'h000, 11'h000, 4'h0};
    tbl[2] = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 1'b1, 11'h000, 11'h001, 11'h000, 4'h0};
    tbl[3] = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h55, 1'b0, 11'h000, 11'h001, 11'h000, 4'h0};
    tbl[4] = '{8'h00, 8'h00, 8'h08, 8'h0C, 8'h00, 1'b1, 11'h000, 11'h001, 11'h000, 4'hC};
    tbl[5] = '{8'h00, 8'hFF, 8'h07, 8'h03, 8'h00, 1'b1, 11'h7FF, 11'h000, 11'h000, 4'h3};

    rst_i = 1'b1; enable_i = 1'b1; uart_rdy_i = 1'b0; uart_err_i = 1'b0; uart_data_i = '0;
    m_ch = '0; m_flags = '0; m_err = 0;
    repeat (3) tick();
    chk_state("reset");
    chk("reset.rstn",   176'(uart_rst_no), 176'(0));
    chk("reset.pulses", 176'({frame_valid_o, frame_err_o}), 176'(0));
    rst_i = 1'b0;
    count_low(n);
    chk("reset.rstlow", 176'(n), 176'(UART_RST_CYCLES));

    // Constant vector table.
    for (int v = 0; v < 6; v++) begin
      pl = {22{tbl[v].fill}};
      pl[7:0]  = tbl[v].b1;
      pl[15:8] = tbl[v].b2;
      do_frame(pl, tbl[v].flags, tbl[v].footer, -1, -1, 0, $sformatf("tbl%0d", v), seen);
      chk($sformatf("tbl%0d.ok", v),   176'(seen), 176'(tbl[v].exp_ok));
      chk($sformatf("tbl%0d.ch0", v),  176'(channels_o[10:0]),    176'(tbl[v].e_ch0));
      chk($sformatf("tbl%0d.ch1", v),  176'(channels_o[21:11]),   176'(tbl[v].e_ch1));
      chk($sformatf("tbl%0d.ch15", v), 176'(channels_o[175:165]), 176'(tbl[v].e_ch15));
      chk($sformatf("tbl%0d.fl", v),   176'({failsafe_o, frame_lost_o, ch18_o, ch17_o}), 176'(tbl[v].e_flags));
    end

    // Receiver error together with a byte strobe at payload byte 10.
    pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
    do_frame(pl, 8'h00, 8'h00, 10, -1, 0, "errwin", seen);

    // Longest allowed gap is accepted.
    pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
    do_frame(pl, 8'h00, 8'h00, -1, 6, GAP_TICKS - 1, "gapok", seen);

    // Gap timeout after payload byte 5.
    send_byte(8'h0F, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    n = 0;
    while (!frame_err_o && n < int'(GAP_TICKS) + 20) begin
      n++;
      tick();
    end
    chk("gap.when", 176'(n), 176'(GAP_TICKS));
    m_err++;
    chk_state("gap");
    count_low(n);
    chk("gap.rstlow", 176'(n), 176'(UART_RST_CYCLES));

    // Garbage before the header is dropped silently.
    send_byte(8'hAA, 1'b0);
    chk("garb.aa", 176'(frame_err_o), 176'(0));
    send_byte(8'h55, 1'b0);
    chk("garb.55", 176'(frame_err_o), 176'(0));
    pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
    do_frame(pl, 8'h0C, 8'h00, -1, -1, 0, "garb", seen);

    // Receiver error while idle: recovery but no pulse or count.
    uart_err_i = 1'b1;
    tick();
    uart_err_i = 1'b0;
    chk("hdrerr.pulse", 176'(frame_err_o), 176'(0));
    count_low(n);
    chk("hdrerr.rstlow", 176'(n), 176'(UART_RST_CYCLES));
    chk_state("hdrerr");

    // Disable mid-frame holds the receiver in reset; re-enable recovers fully.
    send_byte(8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    enable_i = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("dis.rstn", 176'({uart_rst_no, frame_err_o}), 176'(0));
      send_byte(8'h0F, 1'b0);
    end
    enable_i = 1'b1;
    count_low(n);
    chk("dis.rstlow", 176'(n), 176'(UART_RST_CYCLES));
    chk_state("dis");
    pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
    do_frame(pl, 8'h01, 8'h00, -1, -1, 0, "en", seen);

    // Random frames: good, bad footer, receiver error, optional garbage prefix.
    for (int f = 0; f < 40; f++) begin
      int unsigned kind;
      logic [7:0]  g;
      kind = $urandom_range(0, 9);
      pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g == 8'h0F) g = 8'h10;
        send_byte(g, 1'b0);
      end
      if (kind < 6)
        do_frame(pl, 8'($urandom), 8'h00, -1, -1, 0, $sformatf("rnd%0d", f), seen);
      else if (kind < 8)
        do_frame(pl, 8'($urandom), 8'($urandom_range(1, 255)), -1, -1, 0, $sformatf("rnd%0d", f), seen);
      else
        do_frame(pl, 8'($urandom), 8'h00, $urandom_range(1, 24), -1, 0, $sformatf("rnd%0d", f), seen);
    end

    // Reset in the middle of a frame.
    send_byte(8'h0F, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    rst_i = 1'b1;
    tick();
    m_ch = '0; m_flags = '0; m_err = 0;
    chk_state("midrst");
    rst_i = 1'b0;
    count_low(n);
    chk("midrst.rstlow", 176'(n), 176'(UART_RST_CYCLES));

`ifdef SBUS_LINK_WATCHDOG_EN
    repeat (WATCHDOG_TICKS + 5) tick();
    chk("wd.lost", 176'({link_lost_o, failsafe_o}), 176'(2'b11));
    pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
    do_frame(pl, 8'h00, 8'h00, -1, -1, 0, "wdclr", seen);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
